cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the LEGv8 core. It owns the PC and instruction register and runs each instruction through FETCH, DECODE, EXECUTE, MEM and WB, with req/ack handshakes to instruction and data memory. The combinational instruction decoder reads `instr` and returns its control signals, which the sequencer turns into one-cycle strobes and the next-PC update. It replaces single-cycle timing so memories with variable latency can be attached.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_sequencer_if.sv | 25 ++
 rtl/pc_next_calc.sv | 23 ++
 rtl/cpu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle sequencer and its decoder.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  // Opcode fields at their native LEGv8 widths, MSB-aligned in instr[31:...].
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;

  function automatic logic is_mem_op(input logic mem_write, input logic mem_to_reg);
    return mem_write | mem_to_reg;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer and the memories.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 64
);
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: pc + 4, or pc + sign-extended word offset shifted left by 2.
module pc_next_calc #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              uncond_br,
  input  logic              br_taken,
  input  logic [18:0]       cond_addr19,
  input  logic [25:0]       br_addr26,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] off_words;
  logic [ADDR_W-1:0] off_bytes;

  always_comb begin
    off_words = uncond_br ? {{(ADDR_W-26){br_addr26[25]}}, br_addr26}
                          : {{(ADDR_W-19){cond_addr19[18]}}, cond_addr19};
    off_bytes = off_words << 2;
    pc_next   = br_taken ? (pc + off_bytes) : (pc + ADDR_W'(4));
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with req/ack memories and request timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC[ADDR_W-1:0],
  parameter int                MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  cpu_sequencer_if.master    bus,
  output logic [INSTR_W-1:0] instr,
  input  logic               UncondBr,
  input  logic               BrTaken,
  input  logic               RegWrite,
  input  logic               MemWrite,
  input  logic               MemToReg,
  input  logic [18:0]        CondAddr19,
  input  logic [25:0]        BrAddr26,
  output logic               rf_we,
  output logic               retire,
  output logic [ADDR_W-1:0]  pc,
  output logic [31:0]        instr_count,
  output logic [2:0]         state,
  output logic               busy,
  output logic               err
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
  logic               imem_req_q, imem_req_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic               rf_we_q, rf_we_d;
  logic               retire_c;
  logic [ADDR_W-1:0]  pc_next;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc_q),
    .uncond_br   (UncondBr),
    .br_taken    (BrTaken),
    .cond_addr19 (CondAddr19),
    .br_addr26   (BrAddr26),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    retire_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          to_cnt_d = '0;
        end
      end
      S_FETCH: begin
        // Ack wins over an expiring timeout in the same cycle.
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = S_DECODE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_mem_op(MemWrite, MemToReg)) begin
          state_d  = S_MEM;
          to_cnt_d = '0;
        end else if (RegWrite) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (MemToReg) state_d = S_WB;
          else          retire_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_WB:    retire_c = 1'b1;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    if (retire_c) begin
      pc_d     = pc_next;
      cnt_d    = cnt_q + 32'd1;
      to_cnt_d = '0;
      state_d  = run ? S_FETCH : S_IDLE;
    end

    // Strobes are registered from the next state so they never glitch on inputs.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && MemWrite;
    rf_we_d    = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign instr         = instr_q;
  assign rf_we         = rf_we_q;
  assign retire        = retire_c;
  assign pc            = pc_q;
  assign instr_count   = cnt_q;
  assign state         = state_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err           = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays decoder and memories, checking each cycle.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        UncondBr, BrTaken, RegWrite, MemWrite, MemToReg;
  logic [18:0] CondAddr19;
  logic [25:0] BrAddr26;
  logic [31:0] instr;
  logic        rf_we, retire, busy, err;
  logic [63:0] pc;
  logic [31:0] instr_count;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  cpu_sequencer_if #(.ADDR_W(64)) bus ();

  cpu_sequencer #(.ADDR_W(64), .RESET_PC(64'h0), .MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .bus         (bus),
    .instr       (instr),
    .UncondBr    (UncondBr),
    .BrTaken     (BrTaken),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg),
    .CondAddr19  (CondAddr19),
    .BrAddr26    (BrAddr26),
    .rf_we       (rf_we),
    .retire      (retire),
    .pc          (pc),
    .instr_count (instr_count),
    .state       (state),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0;
    UncondBr = 0; BrTaken = 0; RegWrite = 0; MemWrite = 0; MemToReg = 0;
    CondAddr19 = '0; BrAddr26 = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;

    // Reset values
    step(); step();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_count", 64'(instr_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step(); chk("idle_hold", 64'(state), 64'd0);

    // ADDS, zero-wait fetch: 1,2,3,5 then FETCH at pc 4
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAB020020; RegWrite = 1'b1;
    step(); chk("adds_s_fetch", 64'(state), 64'd1);
    chk("adds_imem_req", 64'(bus.imem_req), 64'd1);
    chk("adds_imem_addr", bus.imem_addr, 64'h0);
    chk("adds_busy", 64'(busy), 64'd1);
    step(); chk("adds_s_decode", 64'(state), 64'd2);
    chk("adds_instr", 64'(instr), 64'hAB020020);
    chk("adds_req_drop", 64'(bus.imem_req), 64'd0);
    step(); chk("adds_s_exec", 64'(state), 64'd3);
    chk("adds_exec_noretire", 64'(retire), 64'd0);
    chk("adds_exec_norfwe", 64'(rf_we), 64'd0);
    step(); chk("adds_s_wb", 64'(state), 64'd5);
    chk("adds_wb_rfwe", 64'(rf_we), 64'd1);
    chk("adds_wb_retire", 64'(retire), 64'd1);
    chk("adds_wb_pc_old", pc, 64'h0);
    step(); chk("adds_s_fetch2", 64'(state), 64'd1);
    chk("adds_pc", pc, 64'h4);
    chk("adds_count", 64'(instr_count), 64'd1);
    chk("adds_rfwe_once", 64'(rf_we), 64'd0);

    // Conditional branch taken: pc 4 + 0x3F*4 = 0x100
    RegWrite = 1'b0; BrTaken = 1'b1; CondAddr19 = 19'h0003F; bus.imem_rdata = 32'h540007E0;
    step(); chk("bc_s_decode", 64'(state), 64'd2);
    step(); chk("bc_s_exec", 64'(state), 64'd3);
    chk("bc_retire", 64'(retire), 64'd1);
    step(); chk("bc_s_fetch", 64'(state), 64'd1);
    chk("bc_pc", pc, 64'h100);
    chk("bc_count", 64'(instr_count), 64'd2);

    // Unconditional branch -2 words: 0x100 -> 0xF8
    UncondBr = 1'b1; BrAddr26 = 26'h3FFFFFE; bus.imem_rdata = 32'h17FFFFFE;
    step(); chk("b_s_decode", 64'(state), 64'd2);
    chk("b_rfwe_d", 64'(rf_we), 64'd0);
    step(); chk("b_s_exec", 64'(state), 64'd3);
    chk("b_retire", 64'(retire), 64'd1);
    chk("b_rfwe_e", 64'(rf_we), 64'd0);
    step(); chk("b_s_fetch", 64'(state), 64'd1);
    chk("b_pc", pc, 64'hF8);
    chk("b_count", 64'(instr_count), 64'd3);

    // LDUR, dmem_ack three cycles late: 8 cycles, last MEM cycle also hits timeout boundary
    UncondBr = 1'b0; BrTaken = 1'b0; MemToReg = 1'b1; RegWrite = 1'b1;
    bus.imem_rdata = 32'hF84003E1; bus.dmem_ack = 1'b0;
    step(); chk("ld_s_decode", 64'(state), 64'd2);
    step(); chk("ld_s_exec", 64'(state), 64'd3);
    step(); chk("ld_s_mem1", 64'(state), 64'd4);
    chk("ld_dmem_req", 64'(bus.dmem_req), 64'd1);
    chk("ld_dmem_we", 64'(bus.dmem_we), 64'd0);
    step(); chk("ld_s_mem2", 64'(state), 64'd4);
    step(); chk("ld_s_mem3", 64'(state), 64'd4);
    chk("ld_mem_norfwe", 64'(rf_we), 64'd0);
    step(); chk("ld_s_mem4", 64'(state), 64'd4);
    bus.dmem_ack = 1'b1;
    #1 chk("ld_ack_noretire", 64'(retire), 64'd0);
    step(); chk("ld_s_wb", 64'(state), 64'd5);
    chk("ld_wb_rfwe", 64'(rf_we), 64'd1);
    chk("ld_wb_retire", 64'(retire), 64'd1);
    chk("ld_wb_dreq", 64'(bus.dmem_req), 64'd0);
    chk("ld_err_clear", 64'(err), 64'd0);
    step(); chk("ld_s_fetch", 64'(state), 64'd1);
    chk("ld_pc", pc, 64'hFC);
    chk("ld_count", 64'(instr_count), 64'd4);

    // STUR, zero-wait: 4 cycles, retire in MEM
    MemToReg = 1'b0; RegWrite = 1'b0; MemWrite = 1'b1; bus.imem_rdata = 32'hF80003E1;
    step(); chk("st_s_decode", 64'(state), 64'd2);
    step(); chk("st_s_exec", 64'(state), 64'd3);
    step(); chk("st_s_mem", 64'(state), 64'd4);
    chk("st_dmem_req", 64'(bus.dmem_req), 64'd1);
    chk("st_dmem_we", 64'(bus.dmem_we), 64'd1);
    chk("st_retire", 64'(retire), 64'd1);
    chk("st_rfwe", 64'(rf_we), 64'd0);
    step(); chk("st_s_fetch", 64'(state), 64'd1);
    chk("st_pc", pc, 64'h100);
    chk("st_count", 64'(instr_count), 64'd5);
    chk("st_dreq_drop", 64'(bus.dmem_req), 64'd0);

    // Run dropped during MEM: store completes, then IDLE
    bus.dmem_ack = 1'b0;
    step(); chk("rd_s_decode", 64'(state), 64'd2);
    step(); chk("rd_s_exec", 64'(state), 64'd3);
    step(); chk("rd_s_mem", 64'(state), 64'd4);
    run = 1'b0;
    step(); chk("rd_s_mem_hold", 64'(state), 64'd4);
    bus.dmem_ack = 1'b1;
    #1 chk("rd_retire", 64'(retire), 64'd1);
    step(); chk("rd_s_idle", 64'(state), 64'd0);
    chk("rd_busy", 64'(busy), 64'd0);
    chk("rd_pc", pc, 64'h104);
    chk("rd_count", 64'(instr_count), 64'd6);
    chk("rd_imem_req", 64'(bus.imem_req), 64'd0);
    bus.dmem_ack = 1'b0;
    step(); chk("rd_idle_hold", 64'(state), 64'd0);

    // Fetch timeout with MEM_TIMEOUT=4
    MemWrite = 1'b0; bus.imem_ack = 1'b0; run = 1'b1;
    step(); chk("to_req1", 64'(bus.imem_req), 64'd1);
    step(); chk("to_s2", 64'(state), 64'd1);
    step(); chk("to_s3", 64'(state), 64'd1);
    step(); chk("to_s4", 64'(state), 64'd1);
    chk("to_req4", 64'(bus.imem_req), 64'd1);
    chk("to_err_pre", 64'(err), 64'd0);
    step(); chk("to_s_err", 64'(state), 64'd6);
    chk("to_err", 64'(err), 64'd1);
    chk("to_req_drop", 64'(bus.imem_req), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h12345678;
    step(); step(); chk("to_late_ack_state", 64'(state), 64'd6);
    chk("to_late_ack_instr", 64'(instr), 64'hF80003E1);
    chk("to_err_sticky", 64'(err), 64'd1);

    // Reset clears ERR
    reset_n = 1'b0;
    step(); chk("rc_state", 64'(state), 64'd0);
    chk("rc_err", 64'(err), 64'd0);
    chk("rc_pc", pc, 64'h0);
    reset_n = 1'b1;

    // No-write instruction (3 cycles), then reset asserted mid-fetch
    bus.imem_rdata = 32'hD503201F;
    step(); chk("nw_s_fetch", 64'(state), 64'd1);
    step(); chk("nw_s_decode", 64'(state), 64'd2);
    step(); chk("nw_retire", 64'(retire), 64'd1);
    chk("nw_rfwe", 64'(rf_we), 64'd0);
    step(); chk("nw_s_fetch2", 64'(state), 64'd1);
    chk("nw_pc", pc, 64'h4);
    bus.imem_ack = 1'b0;
    step(); chk("mf_req", 64'(bus.imem_req), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("mf_req_drop", 64'(bus.imem_req), 64'd0);
    chk("mf_pc", pc, 64'h0);
    chk("mf_state", 64'(state), 64'd0);
    chk("mf_count", 64'(instr_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
